// File: rtl/fft_frame_counter.sv
// Sample/frame counter for the FFT datapath: counts accepted samples up to a latched
// frame length, single-shot or continuous. Optional frame counter via FFT_FRAME_CNT_EN.
module fft_frame_counter #(
   parameter int CNT_W = 8,
   parameter int FRM_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] thresh,
   input  logic             start,
   input  logic             valid,
   input  logic             mode_cont,
   input  logic             abort,
   output logic [CNT_W-1:0] cnt,
   output logic             last,
   output logic             full,
   output logic             not_zero,
`ifdef FFT_FRAME_CNT_EN
   output logic [FRM_W-1:0] frame_cnt,
`endif
   output logic             busy
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] thresh_q, thresh_d;
   logic             mode_q, mode_d;
   logic             full_q, full_d;
   logic             not_zero_q, not_zero_d;
   logic             busy_q, busy_d;
   logic             at_last;
`ifdef FFT_FRAME_CNT_EN
   logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
`endif

   // Final sample of the frame is being accepted this cycle.
   assign at_last = (state_q == S_RUN) && valid && (cnt_q == thresh_q);

   // State register: synchronous reset, then abort, then normal operation.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         thresh_q   <= '0;
         mode_q     <= 1'b0;
         full_q     <= 1'b0;
         not_zero_q <= 1'b0;
         busy_q     <= 1'b0;
`ifdef FFT_FRAME_CNT_EN
         frame_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         thresh_q   <= thresh_d;
         mode_q     <= mode_d;
         full_q     <= full_d;
         not_zero_q <= not_zero_d;
         busy_q     <= busy_d;
`ifdef FFT_FRAME_CNT_EN
         frame_cnt_q <= frame_cnt_d;
`endif
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default assignment first so no path through the block infers a latch.
      state_d = state_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (at_last && !mode_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Datapath and registered-status next values.
   always_comb begin
      cnt_d    = cnt_q;
      thresh_d = thresh_q;
      mode_d   = mode_q;
      full_d   = 1'b0;
`ifdef FFT_FRAME_CNT_EN
      frame_cnt_d = frame_cnt_q;
`endif
      if (abort) begin
         // A final sample coinciding with abort is dropped: no full, no frame count.
         cnt_d = '0;
`ifdef FFT_FRAME_CNT_EN
         frame_cnt_d = '0;
`endif
      end else if (state_q == S_IDLE) begin
         cnt_d = '0;
         if (start) begin
            thresh_d = thresh;
            mode_d   = mode_cont;
`ifdef FFT_FRAME_CNT_EN
            frame_cnt_d = '0;
`endif
         end
      end else if (valid) begin
         if (at_last) begin
            cnt_d  = '0;
            full_d = 1'b1;
`ifdef FFT_FRAME_CNT_EN
            frame_cnt_d = frame_cnt_q + 1'b1;
`endif
            if (mode_q) begin
               thresh_d = thresh;
               mode_d   = mode_cont;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      not_zero_d = (cnt_d != '0);
      busy_d     = (state_d == S_RUN);
   end

   // Outputs.
   always_comb begin
      cnt      = cnt_q;
      last     = at_last;
      full     = full_q;
      not_zero = not_zero_q;
      busy     = busy_q;
`ifdef FFT_FRAME_CNT_EN
      frame_cnt = frame_cnt_q;
`endif
   end

endmodule

// File: tb/tb_fft_frame_counter.sv
// Self-checking bench for fft_frame_counter: directed scenarios plus random traffic
// compared against a sample-position reference model. Checks frame_cnt if FFT_FRAME_CNT_EN.
module tb_fft_frame_counter;

   localparam int CNT_W = 8;
   localparam int FRM_W = 8;

   logic             clk;
   logic             rst_n;
   logic [CNT_W-1:0] thresh;
   logic             start;
   logic             valid;
   logic             mode_cont;
   logic             abort;
   logic [CNT_W-1:0] cnt;
   logic             last;
   logic             full;
   logic             not_zero;
   logic             busy;
`ifdef FFT_FRAME_CNT_EN
   logic [FRM_W-1:0] frame_cnt;
`endif

   fft_frame_counter #(.CNT_W(CNT_W), .FRM_W(FRM_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .thresh    (thresh),
      .start     (start),
      .valid     (valid),
      .mode_cont (mode_cont),
      .abort     (abort),
      .cnt       (cnt),
      .last      (last),
      .full      (full),
      .not_zero  (not_zero),
`ifdef FFT_FRAME_CNT_EN
      .frame_cnt (frame_cnt),
`endif
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: position within the frame as a plain integer and frame length
   // as thresh+1, so the wrap is "position reached length".
   bit m_known = 0;
   bit m_run   = 0;
   int m_pos   = 0;
   int m_len   = 1;
   bit m_mode  = 0;
   bit m_full  = 0;
   int m_frames = 0;
   int accepted = 0;

   task automatic model_update();
      if (!rst_n) begin
         m_run = 0; m_pos = 0; m_len = 1; m_mode = 0; m_full = 0; m_frames = 0;
         m_known = 1;
      end else if (abort) begin
         m_run = 0; m_pos = 0; m_full = 0; m_frames = 0;
      end else if (!m_run) begin
         m_full = 0;
         if (start) begin
            m_run = 1; m_pos = 0; m_len = int'(thresh) + 1; m_mode = mode_cont;
            m_frames = 0;
         end
      end else begin
         m_full = 0;
         if (valid) begin
            accepted++;
            m_pos++;
            if (m_pos == m_len) begin
               m_pos = 0;
               m_full = 1;
               m_frames++;
               if (m_mode) begin
                  m_len  = int'(thresh) + 1;
                  m_mode = mode_cont;
               end else begin
                  m_run = 0;
               end
            end
         end
      end
   endtask

   // One clock: drive inputs, check comb last before the edge, check registers after.
   task automatic step(input logic rn, input logic st, input logic vl, input logic mc,
                       input logic ab, input logic [CNT_W-1:0] th);
      bit exp_last;
      rst_n = rn; start = st; valid = vl; mode_cont = mc; abort = ab; thresh = th;
      #3;
      exp_last = m_known && m_run && vl && (m_pos == m_len - 1);
      if (m_known) check("last", 32'(last), 32'(exp_last));
      @(posedge clk);
      model_update();
      #1;
      check("cnt",      32'(cnt),      32'(m_pos));
      check("full",     32'(full),     32'(m_full));
      check("busy",     32'(busy),     32'(m_run));
      check("not_zero", 32'(not_zero), 32'(m_pos != 0));
`ifdef FFT_FRAME_CNT_EN
      check("frame_cnt", 32'(frame_cnt), 32'(m_frames % (1 << FRM_W)));
`endif
   endtask

   initial begin
      int budget;
      rst_n = 1'b0; start = 1'b0; valid = 1'b0; mode_cont = 1'b0; abort = 1'b0;
      thresh = '0;

      // Reset with start and valid asserted
      step(0, 1, 1, 1, 0, 8'd5);
      step(0, 1, 1, 1, 0, 8'd5);
      check("rst_cnt", 32'(cnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      step(1, 0, 0, 0, 0, 8'd0);

      // Single 256-sample frame, back-to-back valids
      step(1, 1, 0, 0, 0, 8'd255);
      for (int i = 0; i < 256; i++) step(1, 0, 1, 0, 0, 8'($urandom));
      check("single_full", 32'(full), 32'd1);
      check("single_busy", 32'(busy), 32'd0);
      step(1, 0, 1, 0, 0, 8'd0);

      // Continuous thresh=3 with ~50% valid until 12 samples accepted
      step(1, 1, 0, 1, 0, 8'd3);
      accepted = 0;
      budget = 0;
      while (accepted < 12 && budget < 500) begin
         step(1, 1'($urandom), 1'($urandom), 1, 0, 8'd3);
         budget++;
      end
      check("cont_done", 32'(accepted >= 12), 32'd1);
      check("cont_frames", 32'(m_frames), 32'd3);
      check("cont_busy", 32'(busy), 32'd1);

      // Abort with final... mid-frame abort with valid, then ignored valids
      step(1, 0, 0, 0, 1, 8'd0);
      step(1, 1, 0, 0, 0, 8'd15);
      for (int i = 0; i < 7; i++) step(1, 0, 1, 0, 0, 8'd15);
      step(1, 0, 1, 0, 1, 8'd15);
      for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 8'd15);
      check("abort_idle", 32'(busy), 32'd0);

      // Abort coincident with the final sample must not pulse full
      step(1, 1, 0, 0, 0, 8'd2);
      step(1, 0, 1, 0, 0, 8'd2);
      step(1, 0, 1, 0, 0, 8'd2);
      step(1, 0, 1, 0, 1, 8'd2);
      // Abort together with start in IDLE stays IDLE
      step(1, 1, 0, 0, 1, 8'd2);

      // thresh=0 continuous, start held high while running
      step(1, 1, 0, 1, 0, 8'd0);
      for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 0, 8'd0);
      check("t0_full", 32'(full), 32'd1);
      check("t0_cnt", 32'(cnt), 32'd0);
      step(1, 0, 0, 0, 1, 8'd0);

      // Random traffic including mid-frame thresh changes, aborts and resets
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) == 0), 1'($urandom),
              1'($urandom), ($urandom_range(0, 79) == 0), 8'($urandom_range(0, 9)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
